// File: rtl/kb_pkg.sv
// kb_pkg: shared types and constants for the keyboard/mouse event queue.
//   kq_state_e   ingress FSM state encoding
//   KB_ENTRY_W   queued entry width; bit 16 is is_mouse, bits 15:0 the word
//   DROP_CNT_MAX saturation value of the drop counter
package kb_pkg;
    typedef enum logic [1:0] {
        KQ_IDLE,
        KQ_ACK,
        KQ_WAIT_CLR
    } kq_state_e;
    localparam int KB_ENTRY_W   = 17;
    localparam int DROP_CNT_MAX = 255;
endpackage

// File: rtl/kb_event_fifo.sv
// kb_event_fifo: synchronous first-word-fall-through FIFO.
//   clk, reset       clock, synchronous active-high reset
//   push_i, wdata_i  write request and data (ignored when full unless popping)
//   pop_i            read request (ignored when empty)
//   rdata_o          head entry, valid whenever empty_o=0
//   full_o, empty_o  status flags
//   count_o          exact occupancy, 0..2**DEPTH_LOG2
module kb_event_fifo #(
    parameter int W          = 17,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [W-1:0]          wdata_i,
    output logic [W-1:0]          rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic [W-1:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q;
    logic                    do_push, do_pop;
    assign do_pop  = pop_i & ~empty_o;
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign do_push = push_i & (~full_o | do_pop);
    assign full_o  = count_q == (DEPTH_LOG2+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(do_push);
            rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(do_pop);
            count_q  <= count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/kb_event_queue.sv
// kb_event_queue: acknowledges keyboard/mouse holding-register words, filters
// repeated mouse reports and buffers events for the host over valid/ready.
//   clk, reset                 clock, synchronous active-high reset
//   data_ready, is_mouse_data,
//   keyboard_data              upstream holding register
//   keyboard_data_retrieved    one-cycle acknowledge to upstream
//   ev_valid, ev_is_mouse,
//   ev_data, ev_ready          FWFT event stream to the host
//   ev_count                   FIFO occupancy
//   overflow, drop_count       sticky drop flag and saturating drop counter
//   overflow_clear             clears overflow and drop_count
module kb_event_queue
    import kb_pkg::*;
#(
    parameter int DEPTH_LOG2       = 3,
    parameter int FILTER_MOUSE_DUP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_ready,
    input  logic                  is_mouse_data,
    input  logic [15:0]           keyboard_data,
    output logic                  keyboard_data_retrieved,
    output logic                  ev_valid,
    output logic                  ev_is_mouse,
    output logic [15:0]           ev_data,
    input  logic                  ev_ready,
    output logic [DEPTH_LOG2:0]   ev_count,
    output logic                  overflow,
    input  logic                  overflow_clear,
    output logic [7:0]            drop_count
);
    kq_state_e               state_q, state_d;
    logic [KB_ENTRY_W-1:0]   hold_q, hold_d, head;
    logic                    retr_q, retr_d;
    logic [15:0]             last_mouse_q, last_mouse_d;
    logic                    lm_valid_q, lm_valid_d;
    logic                    ovf_q, ovf_d;
    logic [7:0]              drop_q, drop_d;
    logic                    full, empty, pop, push, drop, dup, accept;
    kb_event_fifo #(.W(KB_ENTRY_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (hold_q),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (ev_count)
    );
    assign ev_valid                = ~empty;
    assign ev_is_mouse             = head[16];
    assign ev_data                 = head[15:0];
    assign keyboard_data_retrieved = retr_q;
    assign overflow                = ovf_q;
    assign drop_count              = drop_q;
    assign pop    = ev_valid & ev_ready;
    assign accept = state_q == KQ_ACK;
    assign dup    = (FILTER_MOUSE_DUP != 0) && hold_q[16] && lm_valid_q && hold_q[15:0] == last_mouse_q;
    assign push   = accept & ~dup & (~full | pop);
    assign drop   = accept & ~dup & full & ~pop;
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        retr_d       = 1'b0;
        last_mouse_d = last_mouse_q;
        lm_valid_d   = lm_valid_q;
        case (state_q)
            KQ_IDLE: if (data_ready) begin
                hold_d  = {is_mouse_data, keyboard_data};
                retr_d  = 1'b1;
                state_d = KQ_ACK;
            end
            KQ_ACK: state_d = KQ_WAIT_CLR;
            KQ_WAIT_CLR: if (!data_ready) state_d = KQ_IDLE;
            default: state_d = KQ_IDLE;
        endcase
        if (push && hold_q[16]) begin
            last_mouse_d = hold_q[15:0];
            lm_valid_d   = 1'b1;
        end
        // A drop on the clearing edge wins and restarts the count at one.
        ovf_d  = drop ? 1'b1 : overflow_clear ? 1'b0 : ovf_q;
        drop_d = drop ? (overflow_clear ? 8'd1 : drop_q == 8'(DROP_CNT_MAX) ? drop_q : drop_q + 8'd1)
                      : overflow_clear ? 8'd0 : drop_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= KQ_IDLE;
            hold_q       <= '0;
            retr_q       <= 1'b0;
            last_mouse_q <= '0;
            lm_valid_q   <= 1'b0;
            ovf_q        <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            retr_q       <= retr_d;
            last_mouse_q <= last_mouse_d;
            lm_valid_q   <= lm_valid_d;
            ovf_q        <= ovf_d;
            drop_q       <= drop_d;
        end
    end
endmodule
